// File: rtl/ccff_ctrl_pkg.sv
// Shared constants for the configuration-chain controller: FSM encodings,
// CRC-16-CCITT parameters and a width helper. CRC support is built with CCFF_CRC_EN.
package ccff_ctrl_pkg;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_LOAD  = 3'd1;
   localparam logic [2:0] ST_SHIFT = 3'd2;
   localparam logic [2:0] ST_EMIT  = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

   localparam logic [15:0] CRC_POLY = 16'h1021;
   localparam logic [15:0] CRC_INIT = 16'hFFFF;

   // Never returns zero so that degenerate sizes still yield a legal vector width.
   function automatic int clog2(input int value);
      return (value <= 1) ? 1 : $clog2(value);
   endfunction

endpackage

// File: rtl/ccff_crc16_serial.sv
// Bit-serial CRC-16-CCITT accumulator with synchronous clear and shift enable.
// Only present in builds that define CCFF_CRC_EN.
`ifdef CCFF_CRC_EN
module ccff_crc16_serial
   import ccff_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        clr,
   input  logic        en,
   input  logic        din,
   output logic [15:0] crc
);

   logic [15:0] crc_q;
   logic [15:0] crc_d;
   logic        feedback;

   always_comb begin
      feedback = crc_q[15] ^ din;
      crc_d    = crc_q;
      if (en) begin
         crc_d = {crc_q[14:0], 1'b0} ^ (feedback ? CRC_POLY : 16'h0000);
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         crc_q <= CRC_INIT;
      end else begin
         crc_q <= crc_d;
      end
   end

   assign crc = crc_q;

endmodule
`endif

// File: rtl/ccff_chain_ctrl.sv
// Host-side driver for the tile configuration chain: serialises written words into
// ccff_head, or rotates the chain and packs ccff_tail into readback words. CRC output under CCFF_CRC_EN.
module ccff_chain_ctrl
   import ccff_ctrl_pkg::*;
#(
   parameter  int WORD_W    = 32,
   parameter  int CHAIN_LEN = 1024,
   localparam int NWORDS    = (CHAIN_LEN + WORD_W - 1) / WORD_W,
   localparam int CNT_W     = clog2(CHAIN_LEN + 1),
   localparam int IDX_W     = clog2(WORD_W),
   localparam int WC_W      = clog2(NWORDS + 1)
)
(
   input  logic              prog_clk,
   input  logic              pReset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_read,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [WORD_W-1:0] wr_data,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic [WORD_W-1:0] rd_data,
   output logic              config_enable,
   output logic              ccff_head,
   input  logic              ccff_tail,
   output logic              busy,
`ifdef CCFF_CRC_EN
   output logic [15:0]       crc,
`endif
   output logic              done
);

   logic [2:0]        state_q,    state_d;
   logic [CNT_W-1:0]  bit_cnt_q,  bit_cnt_d;
   logic [IDX_W-1:0]  bit_idx_q,  bit_idx_d;
   logic [WC_W-1:0]   word_cnt_q, word_cnt_d;
   logic              rd_mode_q,  rd_mode_d;
   logic [WORD_W-1:0] wr_shreg_q, wr_shreg_d;
   logic [WORD_W-1:0] rd_shreg_q, rd_shreg_d;
   logic              last_bit;
   logic              word_end;

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      bit_idx_d  = bit_idx_q;
      word_cnt_d = word_cnt_q;
      rd_mode_d  = rd_mode_q;
      wr_shreg_d = wr_shreg_q;
      rd_shreg_d = rd_shreg_q;
      last_bit   = (bit_cnt_q == CNT_W'(CHAIN_LEN - 1));
      word_end   = (bit_idx_q == IDX_W'(WORD_W - 1));

      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               rd_mode_d  = cmd_read;
               bit_cnt_d  = '0;
               bit_idx_d  = '0;
               word_cnt_d = '0;
               rd_shreg_d = '0;
               state_d    = cmd_read ? ST_SHIFT : ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (wr_valid) begin
               wr_shreg_d = wr_data;
               bit_idx_d  = '0;
               word_cnt_d = word_cnt_q + WC_W'(1);
               state_d    = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            bit_idx_d = bit_idx_q + IDX_W'(1);
            if (rd_mode_q) begin
               rd_shreg_d[bit_idx_q] = ccff_tail;
            end else begin
               wr_shreg_d = wr_shreg_q >> 1;
            end
            if (word_end || last_bit) begin
               if (rd_mode_q) begin
                  state_d = ST_EMIT;
               end else begin
                  state_d = last_bit ? ST_DONE : ST_LOAD;
               end
            end
         end
         ST_EMIT: begin
            // Readback word stays frozen here; the next word starts from a cleared register so padding reads 0.
            if (rd_ready) begin
               word_cnt_d = word_cnt_q + WC_W'(1);
               if (word_cnt_q == WC_W'(NWORDS - 1)) begin
                  state_d = ST_DONE;
               end else begin
                  rd_shreg_d = '0;
                  bit_idx_d  = '0;
                  state_d    = ST_SHIFT;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge prog_clk) begin
      if (pReset) begin
         state_q    <= ST_IDLE;
         bit_cnt_q  <= '0;
         bit_idx_q  <= '0;
         word_cnt_q <= '0;
         rd_mode_q  <= 1'b0;
         wr_shreg_q <= '0;
         rd_shreg_q <= '0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         bit_idx_q  <= bit_idx_d;
         word_cnt_q <= word_cnt_d;
         rd_mode_q  <= rd_mode_d;
         wr_shreg_q <= wr_shreg_d;
         rd_shreg_q <= rd_shreg_d;
      end
   end

   // The chain only moves in SHIFT; in read mode the tail is looped straight back to the head.
   assign config_enable = (state_q == ST_SHIFT);
   assign ccff_head     = config_enable & (rd_mode_q ? ccff_tail : wr_shreg_q[0]);
   assign cmd_ready     = (state_q == ST_IDLE) & ~pReset;
   assign wr_ready      = (state_q == ST_LOAD);
   assign rd_valid      = (state_q == ST_EMIT);
   assign rd_data       = rd_shreg_q;
   assign busy          = (state_q != ST_IDLE);
   assign done          = (state_q == ST_DONE);

`ifdef CCFF_CRC_EN
   ccff_crc16_serial u_crc (
      .clk (prog_clk),
      .clr (pReset | (cmd_valid & cmd_ready)),
      .en  (config_enable),
      .din (ccff_head),
      .crc (crc)
   );
`endif

endmodule

// File: tb/tb_ccff_chain_ctrl.sv
// Directed bench for ccff_chain_ctrl with a 40-FF behavioural chain (WORD_W=32).
// Define CCFF_CRC_EN to also check the CRC output.
module tb_ccff_chain_ctrl;

   localparam int WORD_W    = 32;
   localparam int CHAIN_LEN = 40;

   logic              clk = 1'b0;
   logic              pReset = 1'b1;
   logic              cmd_valid = 1'b0;
   logic              cmd_ready;
   logic              cmd_read = 1'b0;
   logic              wr_valid = 1'b0;
   logic              wr_ready;
   logic [WORD_W-1:0] wr_data = '0;
   logic              rd_valid;
   logic              rd_ready = 1'b0;
   logic [WORD_W-1:0] rd_data;
   logic              config_enable;
   logic              ccff_head;
   logic              ccff_tail;
   logic              busy;
   logic              done;
`ifdef CCFF_CRC_EN
   logic [15:0]       crc;
`endif

   int checks = 0;
   int failures = 0;

   logic [CHAIN_LEN-1:0] chain = '0;
   int                   shift_cnt = 0;
   int                   wr_hs = 0;
   int                   done_cnt = 0;
   logic                 head_q[$];
   logic [WORD_W-1:0]    rd_words[$];

   always #5 clk = ~clk;

   ccff_chain_ctrl #(.WORD_W(WORD_W), .CHAIN_LEN(CHAIN_LEN)) dut (
      .prog_clk      (clk),
      .pReset        (pReset),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_read      (cmd_read),
      .wr_valid      (wr_valid),
      .wr_ready      (wr_ready),
      .wr_data       (wr_data),
      .rd_valid      (rd_valid),
      .rd_ready      (rd_ready),
      .rd_data       (rd_data),
      .config_enable (config_enable),
      .ccff_head     (ccff_head),
      .ccff_tail     (ccff_tail),
      .busy          (busy),
`ifdef CCFF_CRC_EN
      .crc           (crc),
`endif
      .done          (done)
   );

   // Behavioural chain: the first bit shifted in travels all the way to the tail end.
   assign ccff_tail = chain[0];

   always @(posedge clk) begin
      if (config_enable) begin
         chain     <= {ccff_head, chain[CHAIN_LEN-1:1]};
         shift_cnt <= shift_cnt + 1;
         head_q.push_back(ccff_head);
      end
      if (wr_valid && wr_ready) wr_hs <= wr_hs + 1;
      if (rd_valid && rd_ready) rd_words.push_back(rd_data);
      if (done) done_cnt <= done_cnt + 1;
   end

`ifdef CCFF_CRC_EN
   function automatic logic [15:0] refCrc(input logic [CHAIN_LEN-1:0] bits);
      logic [15:0] c;
      logic        fb;
      c = 16'hFFFF;
      for (int i = 0; i < CHAIN_LEN; i++) begin
         fb = c[15] ^ bits[i];
         c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
      end
      return c;
   endfunction
`endif

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic read);
      cmd_valid = 1'b1;
      cmd_read  = read;
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic waitWrReady(input string tag);
      int n = 0;
      while (!wr_ready && n < 200) begin
         tick();
         n++;
      end
      checkOutput(tag, {63'd0, wr_ready}, 64'd1);
   endtask

   task automatic sendWord(input logic [WORD_W-1:0] w, input string tag);
      waitWrReady(tag);
      wr_valid = 1'b1;
      wr_data  = w;
      tick();
      wr_valid = 1'b0;
   endtask

   task automatic waitDone(input string tag);
      int n = 0;
      while (!done && n < 500) begin
         tick();
         n++;
      end
      checkOutput(tag, {63'd0, done}, 64'd1);
      tick();
   endtask

   task automatic waitRdValid(input string tag);
      int n = 0;
      while (!rd_valid && n < 200) begin
         tick();
         n++;
      end
      checkOutput(tag, {63'd0, rd_valid}, 64'd1);
   endtask

   initial begin
      int                   s0, h0, d0, hs0, r0, n;
      logic [CHAIN_LEN-1:0] head_bits;

      // Reset
      tick();
      checkOutput("rst_cmd_ready_in_reset", {63'd0, cmd_ready}, 64'd0);
      tick();
      pReset = 1'b0;
      #1;
      checkOutput("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
      checkOutput("rst_outputs", {58'd0, config_enable, ccff_head, wr_ready, rd_valid, busy, done}, 64'd0);
      checkOutput("rst_rd_data", {32'd0, rd_data}, 64'd0);
`ifdef CCFF_CRC_EN
      checkOutput("rst_crc", {48'd0, crc}, 64'hFFFF);
`endif

      // Write two words, wr_valid offered as soon as ready
      s0 = shift_cnt; h0 = head_q.size(); d0 = done_cnt; hs0 = wr_hs;
      applyStimulus(1'b0);
      checkOutput("wr_busy", {63'd0, busy}, 64'd1);
      sendWord(32'hA5A5A5A5, "wr1_ready0");
      sendWord(32'h000000C3, "wr1_ready1");
      waitDone("wr1_done");
      checkOutput("wr1_shifts", shift_cnt - s0, 40);
      checkOutput("wr1_handshakes", wr_hs - hs0, 2);
      checkOutput("wr1_done_pulses", done_cnt - d0, 1);
      checkOutput("wr1_chain", {24'd0, chain}, 64'hC3A5A5A5A5);
      head_bits = '0;
      if (head_q.size() >= h0 + CHAIN_LEN)
         for (int i = 0; i < CHAIN_LEN; i++) head_bits[i] = head_q[h0 + i];
      checkOutput("wr1_head_seq", {24'd0, head_bits}, 64'hC3A5A5A5A5);
      checkOutput("wr1_idle", {62'd0, busy, cmd_ready}, 64'd1);
`ifdef CCFF_CRC_EN
      checkOutput("wr1_crc", {48'd0, crc}, {48'd0, refCrc(40'hC3A5A5A5A5)});
`endif

      // Read back with sink always ready
      rd_ready = 1'b1;
      s0 = shift_cnt; r0 = rd_words.size();
      applyStimulus(1'b1);
      waitDone("rd1_done");
      checkOutput("rd1_word_count", rd_words.size() - r0, 2);
      if (rd_words.size() >= r0 + 2) begin
         checkOutput("rd1_word0", {32'd0, rd_words[r0]}, 64'hA5A5A5A5);
         checkOutput("rd1_word1", {32'd0, rd_words[r0+1]}, 64'h000000C3);
      end
      checkOutput("rd1_shifts", shift_cnt - s0, 40);
      checkOutput("rd1_chain_kept", {24'd0, chain}, 64'hC3A5A5A5A5);
`ifdef CCFF_CRC_EN
      checkOutput("rd1_crc", {48'd0, crc}, {48'd0, refCrc(40'hC3A5A5A5A5)});
`endif

      // Read with the sink stalled for 10 cycles at the first word
      rd_ready = 1'b0;
      r0 = rd_words.size();
      applyStimulus(1'b1);
      waitRdValid("rd2_valid");
      s0 = shift_cnt;
      n = 0;
      for (int i = 0; i < 10; i++) begin
         if (config_enable) n++;
         tick();
      end
      checkOutput("rd2_stall_shifts", shift_cnt - s0, 0);
      checkOutput("rd2_stall_enable", n, 0);
      checkOutput("rd2_stall_data", {32'd0, rd_data}, 64'hA5A5A5A5);
      checkOutput("rd2_stall_valid", {63'd0, rd_valid}, 64'd1);
      rd_ready = 1'b1;
      waitDone("rd2_done");
      if (rd_words.size() >= r0 + 2) begin
         checkOutput("rd2_word0", {32'd0, rd_words[r0]}, 64'hA5A5A5A5);
         checkOutput("rd2_word1", {32'd0, rd_words[r0+1]}, 64'h000000C3);
      end else begin
         checkOutput("rd2_word_count", rd_words.size() - r0, 2);
      end
      checkOutput("rd2_chain_kept", {24'd0, chain}, 64'hC3A5A5A5A5);

      // Write with a 5-cycle gap on wr_valid between words
      applyStimulus(1'b0);
      sendWord(32'h12345678, "wr2_ready0");
      waitWrReady("wr2_ready_gap");
      s0 = shift_cnt;
      for (int i = 0; i < 5; i++) tick();
      checkOutput("wr2_gap_shifts", shift_cnt - s0, 0);
      checkOutput("wr2_gap_ready", {63'd0, wr_ready}, 64'd1);
      sendWord(32'h0000005A, "wr2_ready1");
      waitDone("wr2_done");
      checkOutput("wr2_chain", {24'd0, chain}, 64'h5A12345678);

      // Reset in the middle of a write at bit 17
      s0 = shift_cnt;
      applyStimulus(1'b0);
      sendWord(32'hFFFF0000, "wr3_ready0");
      n = 0;
      while ((shift_cnt - s0) < 17 && n < 200) begin
         tick();
         n++;
      end
      checkOutput("wr3_reached_bit17", shift_cnt - s0, 17);
      pReset = 1'b1;
      tick();
      pReset = 1'b0;
      #1;
      checkOutput("abort_config_enable", {63'd0, config_enable}, 64'd0);
      checkOutput("abort_busy", {63'd0, busy}, 64'd0);
      checkOutput("abort_cmd_ready", {63'd0, cmd_ready}, 64'd1);
      checkOutput("abort_rd_valid", {63'd0, rd_valid}, 64'd0);
      s0 = shift_cnt;
      for (int i = 0; i < 5; i++) tick();
      checkOutput("abort_no_shift", shift_cnt - s0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
